// File: rtl/uart_imem_loader_ctrl_pkg.sv
// rtl/uart_imem_loader_ctrl_pkg.sv - shared state encodings and defaults for the UART imem loader
// Purpose: loader FSM state encoding and the default end-of-program marker,
//          shared by the loader, its word assembler and the testbench.
// Ports:   none (package).
package uart_imem_loader_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [31:0] END_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_imem_loader_ctrl_uart_word_assembler.sv
// rtl/uart_imem_loader_ctrl_uart_word_assembler.sv - packs UART bytes LSB first into 32-bit words
// Purpose: owns the byte-lane counter, the 32-bit shift register and the
//          inter-byte timeout counter.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   accept          bytes may be captured (COLLECT or WRITE)
//   collect         loader is in COLLECT (timeout and break are live)
//   rx_valid        1-cycle pulse: rx_data holds a new byte
//   rx_data [7:0]   received byte
//   rx_break        UART BREAK pulse
//   word_valid      pulse: the 4th byte is being captured; word is complete
//                   from the next cycle on
//   word [31:0]     assembled word (lane0 in bits [7:0])
//   drop            pulse: partial word discarded (break or timeout)
module uart_word_assembler
   import uart_imem_loader_ctrl_pkg::*;
#(
   parameter int unsigned BYTE_TIMEOUT = 200000,
   parameter int          TO_W         = 18
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        accept,
   input  logic        collect,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        rx_break,
   output logic        word_valid,
   output logic [31:0] word,
   output logic        drop
);

   logic [1:0]      lane;
   logic [TO_W-1:0] to_cnt;
   logic            brk;
   logic            take;
   logic            timeout;

   // Break beats a simultaneous byte; a byte beats a simultaneous timeout.
   assign brk        = collect && rx_break;
   assign take       = accept && rx_valid && !brk;
   assign timeout    = collect && (lane != 2'd0) && !take && (to_cnt == TO_W'(BYTE_TIMEOUT));
   assign drop       = brk || timeout;
   assign word_valid = take && (lane == 2'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane   <= 2'd0;
         to_cnt <= '0;
         word   <= 32'd0;
      end else if (drop) begin
         // Stale bytes left in word are shifted out by the next four bytes.
         lane   <= 2'd0;
         to_cnt <= '0;
      end else if (take) begin
         word   <= {rx_data, word[31:8]};
         lane   <= lane + 2'd1;   // wraps 3 -> 0 on the last byte
         to_cnt <= '0;
      end else if (collect && (lane != 2'd0)) begin
         to_cnt <= to_cnt + TO_W'(1);
      end else begin
         to_cnt <= '0;
      end
   end

endmodule

// File: rtl/uart_imem_loader_ctrl.sv
// rtl/uart_imem_loader_ctrl.sv - UART boot loader sequencing words into instruction memory
// Purpose: holds the core in reset, writes assembled words to consecutive
//          imem addresses and releases the core when the end marker arrives.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   load_en                level; starts a load from IDLE
//   rx_valid, rx_data[7:0] received byte strobe and data
//   rx_break               UART BREAK pulse
//   imem_we                imem write strobe, 1 cycle per word
//   imem_addr[ADDR_W-1:0]  imem word address
//   imem_wdata[31:0]       instruction written
//   cpu_rst                core reset, high until DONE
//   write_done             sticky load-complete flag
//   word_count[ADDR_W:0]   words written, saturating at 2**ADDR_W
//   err                    sticky timeout/break/overflow flag
module uart_imem_loader_ctrl
   import uart_imem_loader_ctrl_pkg::*;
#(
   parameter int          ADDR_W       = 8,
   parameter logic [31:0] END_WORD     = END_WORD_DEFAULT,
   parameter int unsigned BYTE_TIMEOUT = 200000,
   parameter int          TO_W         = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              rx_break,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              write_done,
   output logic [ADDR_W:0]   word_count,
   output logic              err
);

   localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}};

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr, addr_nxt;
   logic [ADDR_W:0]     count_nxt;
   logic                we_nxt, cpu_rst_nxt, done_nxt, err_nxt;
   logic [ADDR_W-1:0]   iaddr_nxt;
   logic [31:0]         wdata_nxt;

   logic                word_valid;
   logic [31:0]         word;
   logic                drop;

   uart_word_assembler #(
      .BYTE_TIMEOUT (BYTE_TIMEOUT),
      .TO_W         (TO_W)
   ) u_asm (
      .clk        (clk),
      .rst        (rst),
      .accept     ((state == ST_COLLECT) || (state == ST_WRITE)),
      .collect    (state == ST_COLLECT),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_break   (rx_break),
      .word_valid (word_valid),
      .word       (word),
      .drop       (drop)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         addr       <= '0;
         word_count <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'd0;
         cpu_rst    <= 1'b1;
         write_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         addr       <= addr_nxt;
         word_count <= count_nxt;
         imem_we    <= we_nxt;
         imem_addr  <= iaddr_nxt;
         imem_wdata <= wdata_nxt;
         cpu_rst    <= cpu_rst_nxt;
         write_done <= done_nxt;
         err        <= err_nxt;
      end
   end

   // Outputs are registered, so imem_we and write_done appear one cycle
   // after the WRITE cycle (two cycles after the final byte).
   always_comb begin
      state_nxt   = state;
      addr_nxt    = addr;
      count_nxt   = word_count;
      we_nxt      = 1'b0;
      iaddr_nxt   = imem_addr;
      wdata_nxt   = imem_wdata;
      cpu_rst_nxt = cpu_rst;
      done_nxt    = write_done;
      err_nxt     = err;
      case (state)
         ST_IDLE: begin
            cpu_rst_nxt = 1'b1;
            if (load_en) state_nxt = ST_COLLECT;
         end
         ST_COLLECT: begin
            if (drop)       err_nxt   = 1'b1;
            if (word_valid) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            if (word == END_WORD) begin
               state_nxt   = ST_DONE;
               done_nxt    = 1'b1;
               cpu_rst_nxt = 1'b0;
            end else begin
               we_nxt    = 1'b1;
               iaddr_nxt = addr;
               wdata_nxt = word;
               if (word_count != CNT_MAX) count_nxt = word_count + (ADDR_W+1)'(1);
               if (addr == ADDR_TOP) begin
                  // Last imem word used: end the load rather than wrap.
                  err_nxt     = 1'b1;
                  state_nxt   = ST_DONE;
                  done_nxt    = 1'b1;
                  cpu_rst_nxt = 1'b0;
               end else begin
                  addr_nxt  = addr + ADDR_W'(1);
                  state_nxt = ST_COLLECT;
               end
            end
         end
         ST_DONE: begin
            done_nxt    = 1'b1;
            cpu_rst_nxt = 1'b0;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_imem_loader_ctrl.sv
// tb/tb_uart_imem_loader_ctrl.sv - directed self-checking bench for uart_imem_loader_ctrl
module tb_uart_imem_loader_ctrl;
   import uart_imem_loader_ctrl_pkg::*;

   localparam int TO = 50;

   logic        clk = 1'b0;
   logic        rst = 1'b1, rst2 = 1'b1;
   logic        load_en = 1'b0, load_en2 = 1'b0;
   logic        rx_valid = 1'b0, rx_break = 1'b0;
   logic [7:0]  rx_data = 8'd0;

   logic        imem_we, cpu_rst, write_done, err;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [8:0]  word_count;

   logic        imem_we2, cpu_rst2, write_done2, err2;
   logic [1:0]  imem_addr2;
   logic [31:0] imem_wdata2;
   logic [2:0]  word_count2;

   int checks = 0, errors = 0;
   int n_we = 0, n_we2 = 0;
   logic [7:0]  log_addr [0:15];
   logic [31:0] log_data [0:15];
   logic [1:0]  log2_addr [0:15];
   logic [31:0] log2_data [0:15];

   always #5 clk = ~clk;

   uart_imem_loader_ctrl #(.ADDR_W(8), .END_WORD(END_WORD_DEFAULT), .BYTE_TIMEOUT(TO), .TO_W(18)) dut (
      .clk(clk), .rst(rst), .load_en(load_en), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_break(rx_break), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_rst(cpu_rst), .write_done(write_done), .word_count(word_count), .err(err));

   uart_imem_loader_ctrl #(.ADDR_W(2), .END_WORD(END_WORD_DEFAULT), .BYTE_TIMEOUT(TO), .TO_W(18)) dut2 (
      .clk(clk), .rst(rst2), .load_en(load_en2), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_break(rx_break), .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
      .cpu_rst(cpu_rst2), .write_done(write_done2), .word_count(word_count2), .err(err2));

   always @(negedge clk) begin
      if (imem_we && n_we < 16) begin
         log_addr[n_we] = imem_addr;
         log_data[n_we] = imem_wdata;
         n_we = n_we + 1;
      end
      if (imem_we2 && n_we2 < 16) begin
         log2_addr[n_we2] = imem_addr2;
         log2_data[n_we2] = imem_wdata2;
         n_we2 = n_we2 + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
   endtask

   task automatic reset_dut();
      load_en = 1'b0; rx_valid = 1'b0; rx_break = 1'b0;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      n_we = 0;
   endtask

   task automatic start_load();
      load_en = 1'b1;
      tick(1);
   endtask

   initial begin
      tick(2);
      // reset state
      check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      check("rst_we", {31'd0, imem_we}, 32'd0);
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_done", {31'd0, write_done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_count", {23'd0, word_count}, 32'd0);

      // 1: single word, IDLE byte ignored, write latency
      reset_dut();
      send_byte(8'h55, 1);
      start_load();
      send_byte(8'h13, 1); send_byte(8'h01, 1); send_byte(8'h01, 1); send_byte(8'hFF, 0);
      check("t1_lat_we0", {31'd0, imem_we}, 32'd0);
      tick(1);
      check("t1_lat_we1", {31'd0, imem_we}, 32'd1);
      tick(3);
      check("t1_nwe", n_we, 32'd1);
      check("t1_addr", {24'd0, log_addr[0]}, 32'd0);
      check("t1_data", log_data[0], 32'hFF010113);
      check("t1_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      check("t1_count", {23'd0, word_count}, 32'd1);

      // 2: two words then end marker; load_en dropped mid-load
      reset_dut();
      start_load();
      load_en = 1'b0;
      send_word(32'h00112623, 1);
      send_word(32'h00812423, 1);
      send_byte(8'hFF, 1); send_byte(8'hFF, 1); send_byte(8'hFF, 1); send_byte(8'hFF, 0);
      check("t2_done_lat0", {31'd0, write_done}, 32'd0);
      tick(1);
      check("t2_done_lat1", {31'd0, write_done}, 32'd1);
      send_word(32'h11111111, 1);
      tick(3);
      check("t2_nwe", n_we, 32'd2);
      check("t2_addr0", {24'd0, log_addr[0]}, 32'd0);
      check("t2_data0", log_data[0], 32'h00112623);
      check("t2_addr1", {24'd0, log_addr[1]}, 32'd1);
      check("t2_data1", log_data[1], 32'h00812423);
      check("t2_done", {31'd0, write_done}, 32'd1);
      check("t2_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      check("t2_count", {23'd0, word_count}, 32'd2);
      check("t2_err", {31'd0, err}, 32'd0);

      // 3: timeout drops partial word
      reset_dut();
      start_load();
      send_byte(8'hAA, 1); send_byte(8'hBB, 1);
      tick(TO + 10);
      send_word(32'h00000013, 1);
      tick(3);
      check("t3_err", {31'd0, err}, 32'd1);
      check("t3_nwe", n_we, 32'd1);
      check("t3_addr", {24'd0, log_addr[0]}, 32'd0);
      check("t3_data", log_data[0], 32'h00000013);

      // 4: break drops partial word; byte with simultaneous break is dropped
      reset_dut();
      start_load();
      send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1);
      rx_break = 1'b1; tick(1); rx_break = 1'b0;
      rx_break = 1'b1; send_byte(8'hAA, 0); rx_break = 1'b0;
      send_word(32'h12345678, 1);
      tick(3);
      check("t4_err", {31'd0, err}, 32'd1);
      check("t4_nwe", n_we, 32'd1);
      check("t4_addr", {24'd0, log_addr[0]}, 32'd0);
      check("t4_data", log_data[0], 32'h12345678);

      // 6: reset after two words, reload with back-to-back bytes (byte during WRITE)
      reset_dut();
      start_load();
      send_word(32'h00000001, 1);
      send_word(32'h00000002, 1);
      tick(3);
      check("t6_count_pre", {23'd0, word_count}, 32'd2);
      check("t6_addr_pre", {24'd0, imem_addr}, 32'd1);
      rst = 1'b1;
      tick(1);
      check("t6_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      check("t6_addr", {24'd0, imem_addr}, 32'd0);
      check("t6_done", {31'd0, write_done}, 32'd0);
      check("t6_err", {31'd0, err}, 32'd0);
      check("t6_count", {23'd0, word_count}, 32'd0);
      rst = 1'b0;
      n_we = 0;
      start_load();
      send_word(32'hA1B2C3D4, 0);
      send_word(32'h0BADF00D, 0);
      tick(3);
      check("t6_nwe", n_we, 32'd2);
      check("t6_addr0", {24'd0, log_addr[0]}, 32'd0);
      check("t6_data0", log_data[0], 32'hA1B2C3D4);
      check("t6_addr1", {24'd0, log_addr[1]}, 32'd1);
      check("t6_data1", log_data[1], 32'h0BADF00D);

      // 5: ADDR_W=2 overflow
      rst = 1'b1;
      load_en2 = 1'b1;
      rst2 = 1'b1; tick(2); rst2 = 1'b0;
      n_we2 = 0;
      tick(1);
      for (int k = 1; k <= 5; k++) send_word(32'(k), 1);
      tick(3);
      check("t5_nwe", n_we2, 32'd4);
      check("t5_addr3", {30'd0, log2_addr[3]}, 32'd3);
      check("t5_data3", log2_data[3], 32'd4);
      check("t5_err", {31'd0, err2}, 32'd1);
      check("t5_done", {31'd0, write_done2}, 32'd1);
      check("t5_cpu_rst", {31'd0, cpu_rst2}, 32'd0);
      check("t5_count", {29'd0, word_count2}, 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
